nes_pad_reader: RTL and testbench

//  Upstream stage of the CPU's GIO_pins input: polls one NES controller over its 3-wire serial interface.

---
 rtl/nes_pad_reader.sv | 117 +++++++++++
 tb/tb_nes_pad_reader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_reader.sv
// Polls one NES controller over its latch/pulse/data serial link and holds the
// last complete frame as an active-high 8-bit button word.
module nes_pad_reader #(
  parameter int HALF_CYCLES = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic       buttons_valid
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int HW = $clog2(2 * HALF_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LATCH, PULSE_HI, PULSE_LO, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   poll_cnt;
  logic [HW-1:0]   ph, ph_nxt;
  logic [3:0]      idx, idx_nxt;
  logic [7:0]      sr, sr_nxt;
  logic            sync1, sync2;
  logic            poll_tick, phase_end;

  assign poll_tick = (poll_cnt == PW'(POLL_CYCLES - 1));
  // The latch phase spans two half periods; every other phase spans one.
  assign phase_end = (state == LATCH) ? (ph == HW'(2 * HALF_CYCLES - 1))
                                      : (ph == HW'(HALF_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      poll_cnt <= '0;
    end else begin
      sync1    <= nes_data;
      sync2    <= sync1;
      poll_cnt <= poll_tick ? '0 : poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ph    <= '0;
      idx   <= '0;
      sr    <= 8'hFF;
    end else begin
      state <= state_nxt;
      ph    <= ph_nxt;
      idx   <= idx_nxt;
      sr    <= sr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ph_nxt    = ph + 1'b1;
    idx_nxt   = idx;
    sr_nxt    = sr;
    case (state)
      IDLE: begin
        ph_nxt = '0;
        if (poll_tick) state_nxt = LATCH;
      end
      LATCH: if (phase_end) begin
        sr_nxt[0] = ~sync2;
        idx_nxt   = 4'd1;
        ph_nxt    = '0;
        state_nxt = PULSE_HI;
      end
      PULSE_HI: if (phase_end) begin
        ph_nxt    = '0;
        state_nxt = PULSE_LO;
      end
      PULSE_LO: if (phase_end) begin
        ph_nxt = '0;
        // The eighth pulse only shifts the pad past bit 7; its data is dropped.
        if (idx <= 4'd7) sr_nxt[idx[2:0]] = ~sync2;
        if (idx == 4'd8) begin
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 4'd1;
          state_nxt = PULSE_HI;
        end
      end
      DONE: begin
        ph_nxt    = '0;
        state_nxt = IDLE;
      end
      default: begin
        ph_nxt    = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs register the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nes_latch     <= 1'b0;
      nes_pulse     <= 1'b0;
      buttons       <= 8'h00;
      buttons_valid <= 1'b0;
    end else begin
      nes_latch     <= (state_nxt == LATCH);
      nes_pulse     <= (state_nxt == PULSE_HI);
      buttons_valid <= (state_nxt == DONE);
      if (state_nxt == DONE) buttons <= sr_nxt;
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a 4021-style pad model
// (parallel load while latched, shift on the pulse rising edge).
module tb_nes_pad_reader;

  localparam int HALF = 4;
  localparam int POLL = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       nes_latch, nes_pulse, buttons_valid;
  logic [7:0] buttons;
  logic       nes_data;

  logic [7:0] pad_btn = 8'h00;
  logic       tie_high = 1'b0;
  logic [7:0] pad_sr = 8'hFF;
  logic       pad_prev = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  nes_pad_reader #(.HALF_CYCLES(HALF), .POLL_CYCLES(POLL)) dut (
    .clk(clk), .reset(reset), .nes_data(nes_data),
    .nes_latch(nes_latch), .nes_pulse(nes_pulse),
    .buttons(buttons), .buttons_valid(buttons_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad: data is active-low, bit0 (A) presented first.
  always @(posedge clk) begin
    pad_prev <= nes_pulse;
    if (nes_latch) pad_sr <= ~pad_btn;
    else if (nes_pulse && !pad_prev) pad_sr <= {1'b1, pad_sr[7:1]};
  end
  assign nes_data = tie_high ? 1'b1 : pad_sr[0];

  always @(negedge clk)
    assert (!(nes_latch && nes_pulse)) else begin
      $display("FAIL latch_pulse_overlap: latch=%b pulse=%b at cycle %0d, required never both 1",
               nes_latch, nes_pulse, cyc);
      bad++;
    end

  // Follows one frame from latch rise to the end of buttons_valid.
  task automatic capture_frame(input int chg_after, input logic [7:0] chg_val,
                               output logic [7:0] word, output int lat_len, output int npulse,
                               output int nbadw, output int vlen, output logic early,
                               output logic timeout);
    logic [7:0] start_btn;
    logic pp;
    int w, n;
    timeout = 0; early = 0; lat_len = 0; npulse = 0; nbadw = 0; vlen = 0;
    pp = 0; w = 0; n = 0; word = 8'hxx;
    @(negedge clk);
    while (!nes_latch && n < 300) begin @(negedge clk); n++; end
    if (!nes_latch) begin timeout = 1; return; end
    start_btn = buttons;
    n = 0;
    while (!buttons_valid && n < 200) begin
      if (nes_latch) lat_len++;
      if (nes_pulse) begin
        if (!pp) begin
          npulse++; w = 0;
          if (npulse == chg_after) pad_btn = chg_val;
        end
        w++;
      end else if (pp && w != HALF) nbadw++;
      if (buttons !== start_btn) early = 1;
      pp = nes_pulse;
      @(negedge clk); n++;
    end
    if (!buttons_valid) begin timeout = 1; return; end
    word = buttons;
    while (buttons_valid && vlen < 5) begin vlen++; @(negedge clk); end
  endtask

  task automatic test_reset;
    int e, len;
    repeat (3) @(negedge clk);
    total += 4;
    if (nes_latch !== 1'b0) begin $display("FAIL reset_latch: got %b want 0", nes_latch); bad++; end
    if (nes_pulse !== 1'b0) begin $display("FAIL reset_pulse: got %b want 0", nes_pulse); bad++; end
    if (buttons !== 8'h00) begin $display("FAIL reset_buttons: got %h want 00", buttons); bad++; end
    if (buttons_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", buttons_valid); bad++; end
    reset = 1'b1;
    e = 0;
    do begin @(posedge clk); #1; e++; end while (!nes_latch && e < 300);
    total++;
    if (e + 1 != 101) begin $display("FAIL first_latch_cycle: got %0d want 101", e + 1); bad++; end
    len = 0;
    while (nes_latch && len < 50) begin @(posedge clk); #1; len++; end
    total++;
    if (len != 8) begin $display("FAIL latch_len: got %0d want 8", len); bad++; end
    e = 0;
    while (!buttons_valid && e < 200) begin @(negedge clk); e++; end
    @(negedge clk);
  endtask

  task automatic test_word;
    logic [7:0] w; int ll, np, nb, vl; logic early, to;
    pad_btn = 8'h49;
    capture_frame(0, 8'h00, w, ll, np, nb, vl, early, to);
    total += 6;
    if (to) begin $display("FAIL word_timeout: got timeout want frame"); bad++; end
    if (w !== 8'h49) begin $display("FAIL word_value: got %h want 49", w); bad++; end
    if (vl != 1) begin $display("FAIL word_valid_len: got %0d want 1", vl); bad++; end
    if (np != 8) begin $display("FAIL word_pulses: got %0d want 8", np); bad++; end
    if (nb != 0) begin $display("FAIL word_pulse_width: got %0d bad widths want 0", nb); bad++; end
    if (ll != 8 || early) begin
      $display("FAIL word_latch_early: got latch=%0d early=%b want 8,0", ll, early); bad++;
    end
  endtask

  task automatic test_no_pad_and_all;
    logic [7:0] w; int ll, np, nb, vl; logic early, to;
    tie_high = 1'b1; pad_btn = 8'h5A;
    capture_frame(0, 8'h00, w, ll, np, nb, vl, early, to);
    total++;
    if (to || w !== 8'h00) begin $display("FAIL no_pad: got %h to=%b want 00", w, to); bad++; end
    tie_high = 1'b0; pad_btn = 8'hFF;
    capture_frame(0, 8'h00, w, ll, np, nb, vl, early, to);
    total++;
    if (to || w !== 8'hFF) begin $display("FAIL all_pressed: got %h to=%b want ff", w, to); bad++; end
    pad_btn = 8'h00;
    capture_frame(0, 8'h00, w, ll, np, nb, vl, early, to);
    total++;
    if (to || w !== 8'h00) begin $display("FAIL released: got %h to=%b want 00", w, to); bad++; end
  endtask

  task automatic test_mid_frame_change;
    logic [7:0] w; int ll, np, nb, vl; logic early, to;
    pad_btn = 8'h5A;
    capture_frame(0, 8'h00, w, ll, np, nb, vl, early, to);
    total++;
    if (to || w !== 8'h5A) begin $display("FAIL mid_setup: got %h to=%b want 5a", w, to); bad++; end
    capture_frame(4, 8'hA5, w, ll, np, nb, vl, early, to);
    total += 2;
    if (to || w !== 8'h5A) begin $display("FAIL mid_old_word: got %h to=%b want 5a", w, to); bad++; end
    if (early) begin $display("FAIL mid_no_partial: got early change want none"); bad++; end
    capture_frame(0, 8'h00, w, ll, np, nb, vl, early, to);
    total++;
    if (to || w !== 8'hA5) begin $display("FAIL mid_new_word: got %h to=%b want a5", w, to); bad++; end
  endtask

  task automatic test_reset_mid_frame;
    int n, falls, e; logic pp;
    pad_btn = 8'h33;
    n = 0;
    @(negedge clk);
    while (!nes_latch && n < 300) begin @(negedge clk); n++; end
    falls = 0; pp = 0; n = 0;
    while (falls < 5 && n < 200) begin
      @(negedge clk); n++;
      if (pp && !nes_pulse) falls++;
      pp = nes_pulse;
    end
    reset = 1'b0;
    #1;
    total += 2;
    if (nes_latch !== 1'b0 || nes_pulse !== 1'b0 || buttons_valid !== 1'b0) begin
      $display("FAIL abort_ctrl: got latch=%b pulse=%b valid=%b want 0,0,0",
               nes_latch, nes_pulse, buttons_valid); bad++;
    end
    if (buttons !== 8'h00) begin $display("FAIL abort_buttons: got %h want 00", buttons); bad++; end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    e = 0;
    do begin @(posedge clk); #1; e++; end while (!nes_latch && e < 300);
    total++;
    if (e + 1 != 101) begin $display("FAIL restart_latch_cycle: got %0d want 101", e + 1); bad++; end
    e = 0;
    while (!buttons_valid && e < 200) begin @(negedge clk); e++; end
    total++;
    if (!buttons_valid || buttons !== 8'h33) begin
      $display("FAIL restart_word: got %h valid=%b want 33,1", buttons, buttons_valid); bad++;
    end
  endtask

  task automatic test_back_to_back;
    int stamp[3]; int n;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (buttons_valid && n < 10) begin @(negedge clk); n++; end
      n = 0;
      while (!buttons_valid && n < 300) begin @(negedge clk); n++; end
      stamp[f] = buttons_valid ? cyc : -1000 * (f + 1);
    end
    total += 2;
    if (stamp[1] - stamp[0] != POLL) begin
      $display("FAIL valid_period_1: got %0d want %0d", stamp[1] - stamp[0], POLL); bad++;
    end
    if (stamp[2] - stamp[1] != POLL) begin
      $display("FAIL valid_period_2: got %0d want %0d", stamp[2] - stamp[1], POLL); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_no_pad_and_all();
    test_mid_frame_change();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
